ram_bus_master: RTL and testbench



---
 rtl/ram_bus_defs.sv | 19 +
 rtl/ram_bus_master.sv | 154 +++++++++++++++
 tb/tb_ram_bus_master.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bus_defs.sv
`default_nettype none
// ============================================================================
// Module      : ram_bus_defs (package)
// Description : Shared state encodings and wait-counter width for the
//               RAM bus initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_bus_defs;

    // Wait-state counter width; covers the full 0..15 wait-state range.
    localparam int WAIT_CNT_W = 4;

    // Bus-cycle state encodings.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

endpackage : ram_bus_defs
`default_nettype wire

// File: rtl/ram_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : ram_bus_master
// Description : CPU-side request/acknowledge initiator for the 32Kx16
//               byte-capable static RAM. Latches one request, drives the
//               active-low RAM strobes for 1+WAIT_STATES cycles, captures
//               read data and returns a one-cycle acknowledge.
//               Optional build macro MEM_ODD_TRAP_EN: a word access to an
//               odd address skips the RAM cycle and is acknowledged with
//               cpu_err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_bus_master
    import ram_bus_defs::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_byte,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [15:0]       cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_di,
    input  logic [15:0]       ram_do,
    output logic              ram_ce_n,
    output logic              ram_we_n,
    output logic              ram_byte_op
);

    localparam logic [WAIT_CNT_W-1:0] c_WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [WAIT_CNT_W-1:0] c_CNT_ONE   = WAIT_CNT_W'(1);
    // With zero wait states the first ACCESS cycle is already the final one,
    // so the write strobe has to be asserted at the latch edge.
    localparam logic c_WE_AT_LATCH = (c_WAIT_LOAD == '0);

    logic [1:0]            r_state;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic                  r_we;
    logic                  r_ack;
    logic [15:0]           r_rdata;
    logic [ADDR_W-1:0]     r_addr;
    logic [15:0]           r_di;
    logic                  r_ce_n;
    logic                  r_we_n;
    logic                  r_byte;

    logic                  w_final;
    logic                  w_trap;

    assign w_final = (r_cnt == '0);

`ifdef MEM_ODD_TRAP_EN
    logic r_err;

    assign w_trap  = !cpu_byte && cpu_addr[0];
    assign cpu_err = r_err;

    // Error flag rises with the trapped request and falls after its ack cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (r_state == ST_IDLE && cpu_req && w_trap) begin
            r_err <= 1'b1;
        end else if (r_state == ST_DONE) begin
            r_err <= 1'b0;
        end
    end
`else
    assign w_trap  = 1'b0;
    assign cpu_err = 1'b0;
`endif

    // Bus-cycle sequencer: latch request, hold strobes for the wait count,
    // capture read data on the final ACCESS edge, then acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_di    <= '0;
            r_ce_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_byte  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= 1'b0;
                    if (cpu_req) begin
                        if (w_trap) begin
                            // Odd word access: no RAM cycle, straight to ack.
                            r_ack   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_addr  <= cpu_addr;
                            r_di    <= cpu_wdata;
                            r_byte  <= cpu_byte;
                            r_we    <= cpu_we;
                            r_ce_n  <= 1'b0;
                            r_we_n  <= !(cpu_we && c_WE_AT_LATCH);
                            r_cnt   <= c_WAIT_LOAD;
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_final) begin
                        if (!r_we) begin
                            r_rdata <= ram_do;
                        end
                        r_ce_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_ack   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                        // Write strobe covers only the final ACCESS cycle,
                        // giving the RAM exactly one write edge.
                        if (r_we && r_cnt == c_CNT_ONE) begin
                            r_we_n <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    r_ack   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_ack     = r_ack;
    assign cpu_rdata   = r_rdata;
    assign ram_addr    = r_addr;
    assign ram_di      = r_di;
    assign ram_ce_n    = r_ce_n;
    assign ram_we_n    = r_we_n;
    assign ram_byte_op = r_byte;

endmodule : ram_bus_master
`default_nettype wire

// File: tb/tb_ram_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_bus_master
// Description : Self-checking bench for ram_bus_master. Four instances with
//               wait states 1, 0, 15 and 3 share the data inputs, each with
//               its own RAM array; a word-array reference model predicts
//               read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_bus_master;

    localparam int NI = 4;

    function automatic int ws_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            2:       return 15;
            default: return 3;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req [NI];
    logic        we, byt;
    logic [15:0] addr, wdata;
    logic        ack [NI];
    logic        err [NI];
    logic [15:0] rdata [NI];
    logic [15:0] ram_addr [NI];
    logic [15:0] ram_di [NI];
    logic [15:0] ram_do [NI];
    logic        ce_n [NI];
    logic        we_n [NI];
    logic        bop [NI];

    logic [15:0] mem [NI][32768];
    logic        mem_ready = 1'b0;

    logic [15:0] ref_mem [int];
    logic [15:0] model_rd [NI];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Byte-capable RAM: writes on the clock edge while strobes are low.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < NI; k++)
                for (int i = 0; i < 32768; i++)
                    mem[k][i] <= 16'h0000;
            mem_ready <= 1'b1;
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (!ce_n[k] && !we_n[k]) begin
                    if (!bop[k])
                        mem[k][ram_addr[k][15:1]] <= ram_di[k];
                    else if (ram_addr[k][0])
                        mem[k][ram_addr[k][15:1]][15:8] <= ram_di[k][7:0];
                    else
                        mem[k][ram_addr[k][15:1]][7:0] <= ram_di[k][7:0];
                end
            end
        end
    end

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [15:0] w_word;
        assign w_word = mem[g][ram_addr[g][15:1]];
        assign ram_do[g] = bop[g] ? (ram_addr[g][0] ? {8'h00, w_word[15:8]}
                                                    : {8'h00, w_word[7:0]})
                                  : w_word;
        ram_bus_master #(.WAIT_STATES(ws_of(g)), .ADDR_W(16)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .cpu_req     (req[g]),
            .cpu_we      (we),
            .cpu_byte    (byt),
            .cpu_addr    (addr),
            .cpu_wdata   (wdata),
            .cpu_ack     (ack[g]),
            .cpu_err     (err[g]),
            .cpu_rdata   (rdata[g]),
            .ram_addr    (ram_addr[g]),
            .ram_di      (ram_di[g]),
            .ram_do      (ram_do[g]),
            .ram_ce_n    (ce_n[g]),
            .ram_we_n    (we_n[g]),
            .ram_byte_op (bop[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_read(input int k, input logic b, input logic [15:0] a);
        int          key;
        logic [15:0] w;
        key = k * 32768 + int'(a[15:1]);
        w = ref_mem.exists(key) ? ref_mem[key] : 16'h0000;
        if (b) return a[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
        return w;
    endfunction

    task automatic ref_write(input int k, input logic b, input logic [15:0] a, input logic [15:0] d);
        int          key;
        logic [15:0] w;
        key = k * 32768 + int'(a[15:1]);
        w = ref_mem.exists(key) ? ref_mem[key] : 16'h0000;
        if (!b)        w = d;
        else if (a[0]) w = {d[7:0], w[7:0]};
        else           w = {w[15:8], d[7:0]};
        ref_mem[key] = w;
    endtask

    function automatic bit is_trap(input logic b, input logic [15:0] a);
`ifdef MEM_ODD_TRAP_EN
        return !b && a[0];
`else
        return 1'b0 && b && a[0];
`endif
    endfunction

    // Issue one transaction on instance k; lat is the ack cycle counted from
    // the sampling edge E (0 when no ack arrived within the budget).
    task automatic run_txn(input int k, input logic t_we, input logic t_byte,
                           input logic [15:0] t_addr, input logic [15:0] t_wdata,
                           output int lat, output int ce_cnt, output int we_cnt,
                           output int we_at, output logic [15:0] rd, output logic e);
        @(posedge clk); #1;
        we = t_we; byt = t_byte; addr = t_addr; wdata = t_wdata; req[k] = 1'b1;
        lat = 0; ce_cnt = 0; we_cnt = 0; we_at = 0; rd = 16'h0; e = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (!ce_n[k]) ce_cnt++;
            if (!we_n[k]) begin we_cnt++; we_at = n; end
            if (ack[k]) begin
                lat = n; rd = rdata[k]; e = err[k]; req[k] = 1'b0;
                break;
            end
        end
        req[k] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if ({ack[k], err[k], rdata[k], ram_addr[k], ram_di[k], ce_n[k], we_n[k], bop[k]} !==
                {1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL reset_values[%0d]: ack=%b err=%b rd=%h ra=%h di=%h ce_n=%b we_n=%b bop=%b required 0 0 0 0 0 1 1 0",
                         k, ack[k], err[k], rdata[k], ram_addr[k], ram_di[k], ce_n[k], we_n[k], bop[k]);
            end
            model_rd[k] = 16'h0;
        end
        reset = 1'b0;
    endtask

    task automatic test_word_write();
        int lat, cec, wec, wat; logic [15:0] rd; logic e;
        run_txn(0, 1'b1, 1'b0, 16'o000500, 16'o012706, lat, cec, wec, wat, rd, e);
        ref_write(0, 1'b0, 16'o000500, 16'o012706);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL ww_latency: got %0d required 3", lat); end
        n_cmp++; if (wec !== 1 || wat !== 2) begin n_bad++; $display("FAIL ww_we_pulse: got %0d cycles at %0d required 1 at 2", wec, wat); end
        n_cmp++; if (cec !== 2) begin n_bad++; $display("FAIL ww_ce_cycles: got %0d required 2", cec); end
        @(posedge clk); #1;
        n_cmp++; if (ack[0] !== 1'b0) begin n_bad++; $display("FAIL ww_ack_width: ack=%b required 0", ack[0]); end
        run_txn(0, 1'b0, 1'b0, 16'o000500, 16'h0, lat, cec, wec, wat, rd, e);
        model_rd[0] = ref_read(0, 1'b0, 16'o000500);
        n_cmp++; if (rd !== 16'o012706) begin n_bad++; $display("FAIL wr_data: got %o required %o", rd, 16'o012706); end
        n_cmp++; if (e !== 1'b0 || lat !== 3 || wec !== 0) begin n_bad++; $display("FAIL wr_status: err=%b lat=%0d we=%0d required 0 3 0", e, lat, wec); end
    endtask

    task automatic test_byte_lanes();
        int lat, cec, wec, wat; logic [15:0] rd; logic e;
        run_txn(0, 1'b1, 1'b0, 16'o000700, 16'o000000, lat, cec, wec, wat, rd, e);
        ref_write(0, 1'b0, 16'o000700, 16'o000000);
        run_txn(0, 1'b1, 1'b1, 16'o000701, 16'o000252, lat, cec, wec, wat, rd, e);
        ref_write(0, 1'b1, 16'o000701, 16'o000252);
        run_txn(0, 1'b0, 1'b0, 16'o000700, 16'h0, lat, cec, wec, wat, rd, e);
        model_rd[0] = ref_read(0, 1'b0, 16'o000700);
        n_cmp++; if (rd !== 16'o125000) begin n_bad++; $display("FAIL byte_hi_word: got %o required %o", rd, 16'o125000); end
        run_txn(0, 1'b0, 1'b1, 16'o000701, 16'h0, lat, cec, wec, wat, rd, e);
        model_rd[0] = ref_read(0, 1'b1, 16'o000701);
        n_cmp++; if (rd !== 16'o000252) begin n_bad++; $display("FAIL byte_hi_read: got %o required %o", rd, 16'o000252); end
        run_txn(0, 1'b0, 1'b1, 16'o000700, 16'h0, lat, cec, wec, wat, rd, e);
        model_rd[0] = ref_read(0, 1'b1, 16'o000700);
        n_cmp++; if (rd !== 16'o000000) begin n_bad++; $display("FAIL byte_lo_read: got %o required 0", rd); end
    endtask

    task automatic test_back_to_back();
        int a1, a2, hi_cnt; logic [15:0] d1, d2, x1, x2;
        a1 = 0; a2 = 0; hi_cnt = 0; d1 = 16'h0; d2 = 16'h0;
        x1 = ref_read(0, 1'b0, 16'o000500);
        x2 = ref_read(0, 1'b0, 16'o000502);
        @(posedge clk); #1;
        we = 1'b0; byt = 1'b0; addr = 16'o000500; req[0] = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) addr = 16'o000502;
            if (a1 != 0 && ce_n[0]) hi_cnt++;
            if (ack[0]) begin
                if (a1 == 0) begin a1 = n; d1 = rdata[0]; hi_cnt = 1; end
                else begin a2 = n; d2 = rdata[0]; hi_cnt--; req[0] = 1'b0; break; end
            end
        end
        req[0] = 1'b0;
        model_rd[0] = x2;
        n_cmp++; if (a2 - a1 !== 4 || a1 !== 3) begin n_bad++; $display("FAIL b2b_spacing: acks at %0d,%0d required 3,7", a1, a2); end
        n_cmp++; if (hi_cnt !== 2) begin n_bad++; $display("FAIL b2b_ce_gap: got %0d required 2", hi_cnt); end
        n_cmp++; if (d1 !== x1 || d2 !== x2) begin n_bad++; $display("FAIL b2b_data: got %o,%o required %o,%o", d1, d2, x1, x2); end
    endtask

    task automatic test_wait_extremes();
        int lat, cec, wec, wat; logic [15:0] rd, d; logic e;
        for (int k = 1; k <= 2; k++) begin
            d = 16'($urandom);
            run_txn(k, 1'b1, 1'b0, 16'o001234, d, lat, cec, wec, wat, rd, e);
            ref_write(k, 1'b0, 16'o001234, d);
            n_cmp++; if (lat !== ws_of(k) + 2 || cec !== ws_of(k) + 1) begin n_bad++; $display("FAIL ws%0d_write_timing: lat=%0d ce=%0d required %0d %0d", ws_of(k), lat, cec, ws_of(k) + 2, ws_of(k) + 1); end
            n_cmp++; if (wec !== 1 || wat !== ws_of(k) + 1) begin n_bad++; $display("FAIL ws%0d_we_pulse: %0d at %0d required 1 at %0d", ws_of(k), wec, wat, ws_of(k) + 1); end
            run_txn(k, 1'b0, 1'b0, 16'o001234, 16'h0, lat, cec, wec, wat, rd, e);
            model_rd[k] = ref_read(k, 1'b0, 16'o001234);
            n_cmp++; if (rd !== d || lat !== ws_of(k) + 2) begin n_bad++; $display("FAIL ws%0d_read: got %h lat=%0d required %h lat=%0d", ws_of(k), rd, lat, d, ws_of(k) + 2); end
        end
    endtask

    task automatic test_reset_mid_write();
        int lat, cec, wec, wat, acks; logic [15:0] rd, old_v; logic e;
        old_v = 16'hA5C3;
        run_txn(3, 1'b1, 1'b0, 16'o001000, old_v, lat, cec, wec, wat, rd, e);
        ref_write(3, 1'b0, 16'o001000, old_v);
        @(posedge clk); #1;
        we = 1'b1; byt = 1'b0; addr = 16'o001000; wdata = 16'h1111; req[3] = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1; req[3] = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({ack[3], err[3], rdata[3], ram_addr[3], ram_di[3], ce_n[3], we_n[3], bop[3]} !==
            {1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL midreset_values: ack=%b err=%b rd=%h ra=%h di=%h ce_n=%b we_n=%b bop=%b required 0 0 0 0 0 1 1 0",
                     ack[3], err[3], rdata[3], ram_addr[3], ram_di[3], ce_n[3], we_n[3], bop[3]);
        end
        for (int k = 0; k < NI; k++) model_rd[k] = 16'h0;
        reset = 1'b0;
        acks = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (ack[3] || !ce_n[3]) acks++;
        end
        n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL midreset_no_ack: got %0d active cycles required 0", acks); end
        run_txn(3, 1'b0, 1'b0, 16'o001000, 16'h0, lat, cec, wec, wat, rd, e);
        model_rd[3] = ref_read(3, 1'b0, 16'o001000);
        n_cmp++; if (rd !== old_v || lat !== 5) begin n_bad++; $display("FAIL midreset_mem: got %h lat=%0d required %h lat=5", rd, lat, old_v); end
    endtask

    task automatic test_odd_word();
        int lat, cec, wec, wat; logic [15:0] rd, exp_rd; logic e;
        run_txn(0, 1'b0, 1'b0, 16'o000501, 16'h0, lat, cec, wec, wat, rd, e);
`ifdef MEM_ODD_TRAP_EN
        exp_rd = model_rd[0];
        n_cmp++; if (lat !== 1 || e !== 1'b1 || cec !== 0) begin n_bad++; $display("FAIL odd_trap: lat=%0d err=%b ce=%0d required 1 1 0", lat, e, cec); end
`else
        exp_rd = ref_read(0, 1'b0, 16'o000500);
        model_rd[0] = exp_rd;
        n_cmp++; if (lat !== 3 || e !== 1'b0 || cec !== 2) begin n_bad++; $display("FAIL odd_plain: lat=%0d err=%b ce=%0d required 3 0 2", lat, e, cec); end
`endif
        n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL odd_data: got %o required %o", rd, exp_rd); end
        @(posedge clk); #1;
        n_cmp++; if (ack[0] !== 1'b0 || err[0] !== 1'b0) begin n_bad++; $display("FAIL odd_after: ack=%b err=%b required 0 0", ack[0], err[0]); end
    endtask

    task automatic test_random();
        int lat, cec, wec, wat, exp_lat; logic [15:0] rd, a, d, exp_rd; logic e, t_we, t_b;
        for (int i = 0; i < 40; i++) begin
            t_we = 1'($urandom); t_b = 1'($urandom);
            a = 16'o002000 + 16'($urandom_range(0, 15));
            d = 16'($urandom);
            run_txn(0, t_we, t_b, a, d, lat, cec, wec, wat, rd, e);
            if (is_trap(t_b, a)) begin
                exp_lat = 1; exp_rd = model_rd[0];
            end else begin
                exp_lat = 3;
                if (t_we) begin
                    ref_write(0, t_b, a, d);
                    exp_rd = model_rd[0];
                end else begin
                    exp_rd = ref_read(0, t_b, a);
                    model_rd[0] = exp_rd;
                end
            end
            n_cmp++;
            if (rd !== exp_rd || lat !== exp_lat || e !== 1'(is_trap(t_b, a))) begin
                n_bad++;
                $display("FAIL rand[%0d] we=%b b=%b a=%o: rd=%h lat=%0d err=%b required %h %0d %b",
                         i, t_we, t_b, a, rd, lat, e, exp_rd, exp_lat, is_trap(t_b, a));
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin req[k] = 1'b0; model_rd[k] = 16'h0; end
        we = 1'b0; byt = 1'b0; addr = 16'h0; wdata = 16'h0;
        test_reset();
        test_word_write();
        test_byte_lanes();
        test_back_to_back();
        test_wait_extremes();
        test_reset_mid_write();
        test_odd_word();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ram_bus_master
`default_nettype wire
